// File: rtl/mmu_tlb.sv
`default_nettype none
// ============================================================================
//  Module      : mmu_tlb
//  Description : Fully associative MIPS32-style joint TLB. It has a registered
//                lookup port with one cycle of latency and a CP0 management
//                port for TLBWI, TLBWR, TLBP and TLBR. It also holds an
//                internal Random counter that honours Wired.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, rst            clock, synchronous active-high reset
//    req_*  / resp_*     lookup request (vaddr, store) and registered result
//                        (paddr, hit / refill / invalid / modified)
//    op_valid_i, op_i    management strobe and opcode:
//                        1=TLBWI, 2=TLBWR, 3=TLBP, 4=TLBR
//    index_i, wired_i    CP0 Index and Wired
//    entryhi_i, entrylo0_i, entrylo1_i
//                        CP0 write data and probe key
//    asid_i              ASID used by lookups
//    op_done_o           one-cycle pulse after a management strobe
//    probe_o             TLBP result (bit 31 = no match)
//    entryhi_o, entrylo0_o, entrylo1_o
//                        TLBR read data
//    random_o            current Random
//    perf_lookup_o, perf_refill_o
//                        performance counters
//
//  Build option
//    TLB_PERF_CNT_EN     When defined, this enables the mapped-lookup and
//                        refill counters. When it is undefined, both counter
//                        outputs are tied to 0.
// ============================================================================
module mmu_tlb #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4,
    parameter int ASID_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic [31:0]       req_vaddr_i,
    input  logic              req_store_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_paddr_o,
    output logic              resp_hit_o,
    output logic              resp_refill_o,
    output logic              resp_invalid_o,
    output logic              resp_modified_o,
    input  logic              op_valid_i,
    input  logic [2:0]        op_i,
    input  logic [31:0]       index_i,
    input  logic [31:0]       wired_i,
    input  logic [31:0]       entryhi_i,
    input  logic [31:0]       entrylo0_i,
    input  logic [31:0]       entrylo1_i,
    input  logic [ASID_W-1:0] asid_i,
    output logic              op_done_o,
    output logic [31:0]       probe_o,
    output logic [31:0]       entryhi_o,
    output logic [31:0]       entrylo0_o,
    output logic [31:0]       entrylo1_o,
    output logic [IDX_W-1:0]  random_o,
    output logic [31:0]       perf_lookup_o,
    output logic [31:0]       perf_refill_o
);

    localparam logic [2:0] OP_TLBWI = 3'd1;
    localparam logic [2:0] OP_TLBWR = 3'd2;
    localparam logic [2:0] OP_TLBP  = 3'd3;
    localparam logic [2:0] OP_TLBR  = 3'd4;
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(ENTRIES - 1);

    // Entry storage. Only the present bits are reset. The payload is
    // qualified by present, so it does not need a reset.
    logic [ENTRIES-1:0] present;
    logic [ENTRIES-1:0] glb;
    logic [ENTRIES-1:0] d0, v0, d1, v1;
    logic [18:0]        vpn2 [ENTRIES];
    logic [ASID_W-1:0]  asid [ENTRIES];
    logic [19:0]        pfn0 [ENTRIES];
    logic [19:0]        pfn1 [ENTRIES];
    logic [2:0]         c0   [ENTRIES];
    logic [2:0]         c1   [ENTRIES];

    logic [IDX_W-1:0] rnd;
    assign random_o = rnd;

    // ------------------------------------------------------------------
    // Associative match. The loop runs downward so the lowest index wins.
    // ------------------------------------------------------------------
    logic             lk_match, pr_match;
    logic [IDX_W-1:0] lk_idx, pr_idx;

    always_comb begin
        lk_match = 1'b0;
        lk_idx   = '0;
        pr_match = 1'b0;
        pr_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (present[i] && vpn2[i] == req_vaddr_i[31:13] &&
                (glb[i] || asid[i] == asid_i)) begin
                lk_match = 1'b1;
                lk_idx   = IDX_W'(i);
            end
            if (present[i] && vpn2[i] == entryhi_i[31:13] &&
                (glb[i] || asid[i] == entryhi_i[ASID_W-1:0])) begin
                pr_match = 1'b1;
                pr_idx   = IDX_W'(i);
            end
        end
    end

    // kseg0/kseg1 (0x8000_0000..0xBFFF_FFFF) bypass the TLB.
    logic        unmapped;
    logic        pg_v, pg_d;
    logic [19:0] pg_pfn;
    logic        nxt_hit, nxt_refill, nxt_invalid, nxt_modified;
    logic [31:0] nxt_paddr;

    assign unmapped = (req_vaddr_i[31:30] == 2'b10);
    assign pg_v     = req_vaddr_i[12] ? v1[lk_idx]   : v0[lk_idx];
    assign pg_d     = req_vaddr_i[12] ? d1[lk_idx]   : d0[lk_idx];
    assign pg_pfn   = req_vaddr_i[12] ? pfn1[lk_idx] : pfn0[lk_idx];

    always_comb begin
        nxt_hit      = 1'b0;
        nxt_refill   = 1'b0;
        nxt_invalid  = 1'b0;
        nxt_modified = 1'b0;
        nxt_paddr    = '0;
        if (unmapped) begin
            nxt_hit   = 1'b1;
            nxt_paddr = req_vaddr_i[29] ? {3'b000, req_vaddr_i[28:0]}
                                        : {1'b0, req_vaddr_i[30:0]};
        end else if (!lk_match) begin
            nxt_refill = 1'b1;
        end else if (!pg_v) begin
            nxt_invalid = 1'b1;
        end else if (req_store_i && !pg_d) begin
            nxt_modified = 1'b1;
        end else begin
            nxt_hit   = 1'b1;
            nxt_paddr = {pg_pfn, req_vaddr_i[11:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_o    <= 1'b0;
            resp_paddr_o    <= '0;
            resp_hit_o      <= 1'b0;
            resp_refill_o   <= 1'b0;
            resp_invalid_o  <= 1'b0;
            resp_modified_o <= 1'b0;
        end else begin
            resp_valid_o    <= req_valid_i;
            resp_paddr_o    <= req_valid_i ? nxt_paddr : 32'd0;
            resp_hit_o      <= req_valid_i & nxt_hit;
            resp_refill_o   <= req_valid_i & nxt_refill;
            resp_invalid_o  <= req_valid_i & nxt_invalid;
            resp_modified_o <= req_valid_i & nxt_modified;
        end
    end

    // ------------------------------------------------------------------
    // Management port
    // ------------------------------------------------------------------
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic [31:0]      rd_hi, rd_lo0, rd_lo1;

    assign wr_en  = op_valid_i && !rst && (op_i == OP_TLBWI || op_i == OP_TLBWR);
    assign wr_idx = (op_i == OP_TLBWI) ? index_i[IDX_W-1:0] : rnd;
    assign rd_idx = index_i[IDX_W-1:0];

    always_comb begin
        rd_hi                = '0;
        rd_hi[31:13]         = vpn2[rd_idx];
        rd_hi[ASID_W-1:0]    = asid[rd_idx];
        rd_lo0               = {6'b0, pfn0[rd_idx], c0[rd_idx], d0[rd_idx], v0[rd_idx], glb[rd_idx]};
        rd_lo1               = {6'b0, pfn1[rd_idx], c1[rd_idx], d1[rd_idx], v1[rd_idx], glb[rd_idx]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            present <= '0;
        end else if (wr_en) begin
            present[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            vpn2[wr_idx] <= entryhi_i[31:13];
            asid[wr_idx] <= entryhi_i[ASID_W-1:0];
            glb[wr_idx]  <= entrylo0_i[0] & entrylo1_i[0];
            pfn0[wr_idx] <= entrylo0_i[25:6];
            c0[wr_idx]   <= entrylo0_i[5:3];
            d0[wr_idx]   <= entrylo0_i[2];
            v0[wr_idx]   <= entrylo0_i[1];
            pfn1[wr_idx] <= entrylo1_i[25:6];
            c1[wr_idx]   <= entrylo1_i[5:3];
            d1[wr_idx]   <= entrylo1_i[2];
            v1[wr_idx]   <= entrylo1_i[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_done_o  <= 1'b0;
            probe_o    <= 32'h8000_0000;
            entryhi_o  <= '0;
            entrylo0_o <= '0;
            entrylo1_o <= '0;
        end else begin
            op_done_o <= op_valid_i;
            if (op_valid_i && op_i == OP_TLBP) begin
                probe_o <= pr_match ? {{(32-IDX_W){1'b0}}, pr_idx} : 32'h8000_0000;
            end
            if (op_valid_i && op_i == OP_TLBR) begin
                entryhi_o  <= rd_hi;
                entrylo0_o <= rd_lo0;
                entrylo1_o <= rd_lo1;
            end
        end
    end

    // Random: it counts down and wraps to the top once it reaches Wired or
    // zero. Wired at or beyond the depth pins it at the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            rnd <= TOP_IDX;
        end else if (wired_i[IDX_W]) begin
            rnd <= TOP_IDX;
        end else if ({1'b0, rnd} <= wired_i[IDX_W:0] || rnd == '0) begin
            rnd <= TOP_IDX;
        end else begin
            rnd <= rnd - 1'b1;
        end
    end

`ifdef TLB_PERF_CNT_EN
    logic [31:0] perf_lookup_cnt, perf_refill_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lookup_cnt <= '0;
            perf_refill_cnt <= '0;
        end else begin
            if (req_valid_i && !unmapped) perf_lookup_cnt <= perf_lookup_cnt + 32'd1;
            if (req_valid_i && nxt_refill) perf_refill_cnt <= perf_refill_cnt + 32'd1;
        end
    end

    assign perf_lookup_o = perf_lookup_cnt;
    assign perf_refill_o = perf_refill_cnt;
`else
    assign perf_lookup_o = '0;
    assign perf_refill_o = '0;
`endif

    // Register bits that the CP0 formats define but this TLB does not use.
    logic unused_bits;
    assign unused_bits = ^{index_i[31:IDX_W], wired_i[31:IDX_W+1], entryhi_i[12:ASID_W],
                           entrylo0_i[31:26], entrylo1_i[31:26]};

endmodule
`default_nettype wire

// File: tb/tb_mmu_tlb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmu_tlb
//  Description : Directed self-checking bench for mmu_tlb. Every expected
//                value in this bench was computed by hand.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mmu_tlb;
    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;
    localparam int ASID_W  = 8;

    localparam logic [4:0] K_IDLE = 5'b00000;  // {valid,hit,refill,invalid,modified}
    localparam logic [4:0] K_HIT  = 5'b11000;
    localparam logic [4:0] K_REF  = 5'b10100;
    localparam logic [4:0] K_INV  = 5'b10010;
    localparam logic [4:0] K_MOD  = 5'b10001;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid_i, req_store_i;
    logic [31:0]       req_vaddr_i;
    logic              resp_valid_o, resp_hit_o, resp_refill_o, resp_invalid_o, resp_modified_o;
    logic [31:0]       resp_paddr_o;
    logic              op_valid_i;
    logic [2:0]        op_i;
    logic [31:0]       index_i, wired_i, entryhi_i, entrylo0_i, entrylo1_i;
    logic [ASID_W-1:0] asid_i;
    logic              op_done_o;
    logic [31:0]       probe_o, entryhi_o, entrylo0_o, entrylo1_o;
    logic [IDX_W-1:0]  random_o;
    logic [31:0]       perf_lookup_o, perf_refill_o;

    int compared   = 0;
    int mismatched = 0;

    mmu_tlb #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .ASID_W(ASID_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_vaddr_i(req_vaddr_i), .req_store_i(req_store_i),
        .resp_valid_o(resp_valid_o), .resp_paddr_o(resp_paddr_o), .resp_hit_o(resp_hit_o),
        .resp_refill_o(resp_refill_o), .resp_invalid_o(resp_invalid_o),
        .resp_modified_o(resp_modified_o),
        .op_valid_i(op_valid_i), .op_i(op_i), .index_i(index_i), .wired_i(wired_i),
        .entryhi_i(entryhi_i), .entrylo0_i(entrylo0_i), .entrylo1_i(entrylo1_i),
        .asid_i(asid_i), .op_done_o(op_done_o), .probe_o(probe_o),
        .entryhi_o(entryhi_o), .entrylo0_o(entrylo0_o), .entrylo1_o(entrylo1_o),
        .random_o(random_o), .perf_lookup_o(perf_lookup_o), .perf_refill_o(perf_refill_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] va, input logic st);
        req_valid_i = 1'b1;
        req_vaddr_i = va;
        req_store_i = st;
        tick();
        req_valid_i = 1'b0;
        req_store_i = 1'b0;
    endtask

    task automatic chk_resp(input string tag, input logic [4:0] kind, input logic [31:0] pa);
        check({tag, " flags"},
              {59'd0, resp_valid_o, resp_hit_o, resp_refill_o, resp_invalid_o, resp_modified_o},
              {59'd0, kind});
        if (kind == K_HIT || kind == K_IDLE) check({tag, " paddr"}, {32'd0, resp_paddr_o}, {32'd0, pa});
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] idx, input logic [31:0] hi,
                         input logic [31:0] lo0, input logic [31:0] lo1);
        op_valid_i = 1'b1;
        op_i       = op;
        index_i    = idx;
        entryhi_i  = hi;
        entrylo0_i = lo0;
        entrylo1_i = lo1;
        tick();
        op_valid_i = 1'b0;
        op_i       = 3'd0;
    endtask

    task automatic chk_read(input string tag, input logic [31:0] idx, input logic [31:0] hi,
                            input logic [31:0] lo0, input logic [31:0] lo1);
        do_op(3'd4, idx, 32'd0, 32'd0, 32'd0);
        check({tag, " hi"},  {32'd0, entryhi_o},  {32'd0, hi});
        check({tag, " lo0"}, {32'd0, entrylo0_o}, {32'd0, lo0});
        check({tag, " lo1"}, {32'd0, entrylo1_o}, {32'd0, lo1});
    endtask

    initial begin
        logic [IDX_W-1:0] exp_rnd;
        logic [IDX_W-1:0] last_r;
        logic [31:0]      last_hi;
        int               bad;
        logic             found;

        rst = 1'b1; req_valid_i = 1'b0; req_store_i = 1'b0; req_vaddr_i = '0;
        op_valid_i = 1'b0; op_i = '0; index_i = '0; wired_i = '0;
        entryhi_i = '0; entrylo0_i = '0; entrylo1_i = '0; asid_i = 8'd5;
        tick();
        tick();

        // Reset state
        chk_resp("reset resp", K_IDLE, 32'd0);
        check("reset probe", {32'd0, probe_o}, 64'h8000_0000);
        check("reset random", {60'd0, random_o}, 64'd15);
        check("reset op_done", {63'd0, op_done_o}, 64'd0);
        check("reset entryhi", {32'd0, entryhi_o}, 64'd0);
        rst = 1'b0;
        tick();
        check("random first decrement", {60'd0, random_o}, 64'd14);

        // Empty TLB and the unmapped windows
        lookup(32'h0040_0000, 1'b0); chk_resp("empty refill", K_REF, 32'd0);
        lookup(32'h8012_3456, 1'b0); chk_resp("kseg0", K_HIT, 32'h0012_3456);
        lookup(32'hA000_1000, 1'b0); chk_resp("kseg1", K_HIT, 32'h0000_1000);
        lookup(32'h9FFF_FFFF, 1'b1); chk_resp("kseg0 top store", K_HIT, 32'h1FFF_FFFF);
        lookup(32'hBFFF_FFFF, 1'b0); chk_resp("kseg1 top", K_HIT, 32'h1FFF_FFFF);
        lookup(32'hC000_0000, 1'b0); chk_resp("kseg2 mapped", K_REF, 32'd0);
        lookup(32'h7FFF_E000, 1'b0); chk_resp("kuseg top mapped", K_REF, 32'd0);
        tick();                      chk_resp("idle", K_IDLE, 32'd0);

        // TLBWI entry 3: even page D,V and odd page V only
        do_op(3'd1, 32'd3, 32'h0040_0005, 32'h0000_1046, 32'h0000_1042);
        check("wi op_done", {63'd0, op_done_o}, 64'd1);
        tick();
        check("op_done one cycle", {63'd0, op_done_o}, 64'd0);
        lookup(32'h0040_0ABC, 1'b0); chk_resp("even load", K_HIT, 32'h0004_1ABC);
        lookup(32'h0040_1ABC, 1'b1); chk_resp("odd store", K_MOD, 32'd0);
        lookup(32'h0040_0ABC, 1'b1); chk_resp("even store", K_HIT, 32'h0004_1ABC);
        lookup(32'h0040_1ABC, 1'b0); chk_resp("odd load", K_HIT, 32'h0004_1ABC);
        asid_i = 8'd6;
        lookup(32'h0040_0ABC, 1'b0); chk_resp("asid mismatch", K_REF, 32'd0);

        // Entry 5 with V=0 on both pages: invalid
        do_op(3'd1, 32'd5, 32'h0080_0006, 32'h0000_1040, 32'h0000_1040);
        lookup(32'h0080_0123, 1'b0); chk_resp("invalid page", K_INV, 32'd0);

        // Entry 3 is made global, so ASID 6 matches
        do_op(3'd1, 32'd3, 32'h0040_0005, 32'h0000_1047, 32'h0000_1043);
        lookup(32'h0040_0ABC, 1'b0); chk_resp("global hit", K_HIT, 32'h0004_1ABC);

        // A write and a lookup at the same edge: the lookup sees old contents
        op_valid_i = 1'b1; op_i = 3'd1; index_i = 32'd3; entryhi_i = 32'h0040_0005;
        entrylo0_i = 32'h0000_2047; entrylo1_i = 32'h0000_2043;
        req_valid_i = 1'b1; req_vaddr_i = 32'h0040_0ABC;
        tick();
        op_valid_i = 1'b0; req_valid_i = 1'b0;
        chk_resp("same-edge old", K_HIT, 32'h0004_1ABC);
        lookup(32'h0040_0ABC, 1'b0); chk_resp("after write new", K_HIT, 32'h0008_1ABC);

        // Probe and read
        do_op(3'd3, 32'd0, 32'h0040_0005, 32'd0, 32'd0);
        check("probe hit", {32'd0, probe_o}, 64'h0000_0003);
        do_op(3'd3, 32'd0, 32'h0080_0005, 32'd0, 32'd0);
        check("probe miss", {32'd0, probe_o}, 64'h8000_0000);
        chk_read("tlbr 3", 32'd3, 32'h0040_0005, 32'h0000_2047, 32'h0000_2043);
        do_op(3'd1, 32'd7, 32'h0060_1F05, 32'hFC00_1047, 32'h0000_1042);
        chk_read("tlbr 7 unstored", 32'd7, 32'h0060_0005, 32'h0000_1046, 32'h0000_1042);

        // Duplicate match: the lowest index wins
        do_op(3'd1, 32'd1, 32'h0040_0005, 32'h0000_3047, 32'h0000_3043);
        lookup(32'h0040_0ABC, 1'b0); chk_resp("lowest index wins", K_HIT, 32'h000C_1ABC);
        do_op(3'd3, 32'd0, 32'h0040_0005, 32'd0, 32'd0);
        check("probe lowest", {32'd0, probe_o}, 64'h0000_0001);

        // Random with Wired = 12
        wired_i = 32'd12;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (random_o == 4'd15) found = 1'b1;
        end
        check("random sync", {63'd0, found}, 64'd1);
        exp_rnd = 4'd15;
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_rnd = (exp_rnd == 4'd12) ? 4'd15 : exp_rnd - 4'd1;
            check($sformatf("random seq %0d", k), {60'd0, random_o}, {60'd0, exp_rnd});
        end

        // 100 TLBWR operations must land in entries 12..15 only
        bad = 0;
        last_r = '0;
        last_hi = '0;
        for (int k = 0; k < 100; k++) begin
            if (random_o < 4'd12) bad++;
            last_r  = random_o;
            last_hi = 32'h0F00_0005 + (k << 13);
            do_op(3'd2, 32'd0, last_hi, 32'h0000_1046, 32'h0000_1046);
        end
        check("tlbwr below wired", 64'(bad), 64'd0);
        chk_read("tlbwr target", {28'd0, last_r}, last_hi, 32'h0000_1046, 32'h0000_1046);
        chk_read("wired entry 1", 32'd1, 32'h0040_0005, 32'h0000_3047, 32'h0000_3043);
        chk_read("wired entry 3", 32'd3, 32'h0040_0005, 32'h0000_2047, 32'h0000_2043);
        chk_read("wired entry 5", 32'd5, 32'h0080_0006, 32'h0000_1040, 32'h0000_1040);
        chk_read("wired entry 7", 32'd7, 32'h0060_0005, 32'h0000_1046, 32'h0000_1042);

        // Wired at the depth pins Random at the top
        wired_i = 32'd16;
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("random pinned %0d", k), {60'd0, random_o}, 64'd15);
        end
        wired_i = 32'd0;

        // Reset during a lookup and an op discards both
        rst = 1'b1; req_valid_i = 1'b1; req_vaddr_i = 32'h8000_0000;
        op_valid_i = 1'b1; op_i = 3'd3; entryhi_i = 32'h0040_0005;
        tick();
        rst = 1'b0; req_valid_i = 1'b0; op_valid_i = 1'b0;
        chk_resp("rst discards resp", K_IDLE, 32'd0);
        check("rst discards op", {63'd0, op_done_o}, 64'd0);
        check("rst probe", {32'd0, probe_o}, 64'h8000_0000);

        // Entries are cleared, then perf traffic: 10 mapped lookups (4 refills) and 3 kseg0
        asid_i = 8'd5;
        lookup(32'h0040_0ABC, 1'b0); chk_resp("post-reset refill", K_REF, 32'd0);
        do_op(3'd1, 32'd2, 32'h0040_0005, 32'h0000_1046, 32'h0000_1046);
        for (int k = 0; k < 6; k++) lookup(32'h0040_0000 + 32'(k * 4), 1'b0);
        chk_resp("perf last hit", K_HIT, 32'h0004_1014);
        for (int k = 0; k < 3; k++) lookup(32'h0050_0000, 1'b0);
        for (int k = 0; k < 3; k++) lookup(32'h8000_0100, 1'b0);
        tick();
`ifdef TLB_PERF_CNT_EN
        check("perf lookups", {32'd0, perf_lookup_o}, 64'd10);
        check("perf refills", {32'd0, perf_refill_o}, 64'd4);
`else
        check("perf lookups tied", {32'd0, perf_lookup_o}, 64'd0);
        check("perf refills tied", {32'd0, perf_refill_o}, 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Keep a runaway simulation from hanging.
    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
